mux_rr_arbiter: RTL and testbench
=================================

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter: HOLD_CYCLES, default 4, maximum grant length in clock cycles (legal 1..16).
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  16  request line per source; bit i = source i.
REQ-005 Port: data_in  input  16  shared 16:1 datapath inputs; bit i belongs to source i.
REQ-006 Port: release  input  1  early end of the current grant.
REQ-007 Port: sel  output  4  binary index of the granted source (mux select).
REQ-008 Port: gnt  output  16  one-hot grant; all-zero when no grant.
REQ-009 Port: gnt_valid  output  1  high while a grant is active.
REQ-010 Port: data_out  output  1  registered data_in[sel] sampled during a grant.
REQ-011 Port: dout_valid  output  1  high when data_out holds a sample from the previous cycle's grant.

Function
REQ-012 The block SHALL have three states: IDLE, GRANT, GUARD, all registered.
REQ-013 IDLE: if req != 0 at an edge, the next state SHALL be GRANT with the arbitration winner; otherwise it SHALL stay IDLE.
REQ-014 Arbitration SHALL be round-robin: scan indices ptr+1, ptr+2, ... mod 16, ending at ptr itself; the winner is the first index with req set.
REQ-015 On entry to GRANT: sel = winner, gnt = 1<<winner, gnt_valid = 1, ptr = winner, hold counter = 0. All four SHALL update on the same edge.
REQ-016 In GRANT, the hold counter (5 bits) SHALL increment each cycle.
REQ-017 GRANT SHALL end at an edge where any of these holds: release = 1; req[sel] = 0; hold counter = HOLD_CYCLES-1.
REQ-018 A grant SHALL therefore last 1..HOLD_CYCLES cycles.
REQ-019 When GRANT ends, the next state SHALL be GUARD: gnt = 0, gnt_valid = 0, sel holds its last value.
REQ-020 GUARD SHALL last exactly one cycle. At its ending edge, req != 0 goes to GRANT (same arbitration as REQ-014); req == 0 goes to IDLE.
REQ-021 A sole requester SHALL be re-granted after its GUARD cycle, because ptr is the last index scanned.
REQ-022 At each edge in GRANT, data_out SHALL load data_in[sel] and dout_valid SHALL be 1.
REQ-023 At each edge outside GRANT, dout_valid SHALL be 0 and data_out SHALL hold its value.
REQ-024 release or req changes in IDLE or GUARD SHALL only affect arbitration; release outside GRANT has no effect.
REQ-025 gnt SHALL never have more than one bit set, and gnt[sel] SHALL equal gnt_valid at all times.

Reset
REQ-026 When rst_n = 0, immediately and regardless of clk: state = IDLE, sel = 0, gnt = 0, gnt_valid = 0, data_out = 0, dout_valid = 0, hold counter = 0, ptr = 15.
REQ-027 Reset asserted mid-grant SHALL abort the grant with no GUARD cycle.
REQ-028 After reset release, the first grant SHALL follow REQ-013 starting from ptr = 15, so source 0 has first priority.

Verification
REQ-029 Reset: rst_n = 0 mid-cycle -> all outputs 0 without a clock edge; after release with req = 0, the block stays IDLE and gnt stays 0.
REQ-030 Sole requester, req = 16'h0020, HOLD_CYCLES = 4 -> sel = 5, gnt = 16'h0020 for 4 cycles, 1 GUARD cycle with gnt = 0, then re-grant of 5. With data_in = 16'h0020, data_out = 1 and dout_valid = 1 from the 2nd through 5th cycle after grant entry.
REQ-031 Fairness, req = 16'h8001 held -> grant order 0, 15, 0, 15, each grant 4 cycles, separated by single GUARD cycles.
REQ-032 Early release: release = 1 during the 2nd grant cycle -> GUARD on that edge; grant length 2; a pending req[3] is granted after GUARD.
REQ-033 Request drop: req[7] cleared during grant of 7 -> GUARD at the next edge; with req = 0, IDLE follows.
REQ-034 Reset mid-grant of source 9 -> outputs 0 at once; after release with req = 16'h0201, source 0 is granted first.

Source files
------------

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: 16-source round-robin arbiter that also drives the select of
// a shared 16:1 datapath mux. Each grant lasts at most HOLD_CYCLES cycles and
// can end early on release_i or when the granted source drops its request.
// Every grant is followed by exactly one GUARD cycle with no grant. While a
// grant is active, the selected data bit is registered on every edge.
//
// Port note: the early-release input is called release_i because "release"
// is a reserved word in SystemVerilog.

module mux_rr_arbiter #(
  parameter int HOLD_CYCLES = 4   // maximum grant length in cycles, 1..16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic [15:0] data_in,
  input  logic        release_i,
  output logic [3:0]  sel,
  output logic [15:0] gnt,
  output logic        gnt_valid,
  output logic        data_out,
  output logic        dout_valid
);

  // State encoding (kept as plain constants so older tools can read them).
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;

  // The last hold-counter value a grant may reach before it is forced to end.
  localparam logic [4:0] HOLD_LAST = 5'(HOLD_CYCLES - 1);

  // Round-robin pick. The scan starts at ptr+1 and wraps back to ptr itself,
  // so the previous winner has the lowest priority. A sole requester is
  // nevertheless granted again, because ptr is still part of the scan.
  // Result: {hit, index}. Scanning from the far end down lets the nearest
  // candidate overwrite all others, so no early exit is needed.
  function automatic logic [4:0] rr_pick(input logic [15:0] r, input logic [3:0] p);
    logic [4:0] res;
    logic [3:0] cand;
    res = 5'd0;
    for (int k = 16; k >= 1; k--) begin
      cand = p + 4'(k);
      res  = r[cand] ? {1'b1, cand} : res;
    end
    return res;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic [15:0] gnt_q, gnt_d;
  logic        gnt_valid_q, gnt_valid_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [4:0]  hold_q, hold_d;
  logic        data_out_q, data_out_d;
  logic        dout_valid_q, dout_valid_d;

  logic [4:0]  pick_s;
  logic        pick_hit_s;
  logic [3:0]  pick_idx_s;
  logic        grant_end_s;

  // The arbitration result and the grant-termination condition.
  always_comb begin
    pick_s      = rr_pick(req, ptr_q);
    pick_hit_s  = pick_s[4];
    pick_idx_s  = pick_s[3:0];
    grant_end_s = release_i | ~req[sel_q] | (hold_q == HOLD_LAST);
  end

  // Next-state logic: walks IDLE -> GRANT -> GUARD -> (GRANT | IDLE).
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    gnt_d        = gnt_q;
    gnt_valid_d  = gnt_valid_q;
    ptr_d        = ptr_q;
    hold_d       = hold_q;
    data_out_d   = data_out_q;
    dout_valid_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_GUARD: begin
        // release_i is ignored here. Only the request vector matters.
        if (pick_hit_s) begin
          state_d     = ST_GRANT;
          sel_d       = pick_idx_s;
          gnt_d       = 16'd1 << pick_idx_s;
          gnt_valid_d = 1'b1;
          ptr_d       = pick_idx_s;
          hold_d      = 5'd0;
        end else begin
          state_d     = ST_IDLE;
          gnt_d       = 16'd0;
          gnt_valid_d = 1'b0;
        end
      end

      ST_GRANT: begin
        // Each edge of an active grant captures the selected data bit.
        data_out_d   = data_in[sel_q];
        dout_valid_d = 1'b1;
        if (grant_end_s) begin
          // sel keeps its last value through GUARD.
          state_d     = ST_GUARD;
          gnt_d       = 16'd0;
          gnt_valid_d = 1'b0;
        end else begin
          hold_d = hold_q + 5'd1;
        end
      end

      default: begin
        // Unreachable encoding: fall back to a quiet IDLE.
        state_d     = ST_IDLE;
        gnt_d       = 16'd0;
        gnt_valid_d = 1'b0;
        hold_d      = 5'd0;
      end
    endcase
  end

  // State and output registers. Reset is asynchronous and also aborts an
  // in-flight grant, with no GUARD cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= 4'd0;
      gnt_q        <= 16'd0;
      gnt_valid_q  <= 1'b0;
      ptr_q        <= 4'd15;
      hold_q       <= 5'd0;
      data_out_q   <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      gnt_q        <= gnt_d;
      gnt_valid_q  <= gnt_valid_d;
      ptr_q        <= ptr_d;
      hold_q       <= hold_d;
      data_out_q   <= data_out_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign sel        = sel_q;
  assign gnt        = gnt_q;
  assign gnt_valid  = gnt_valid_q;
  assign data_out   = data_out_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Testbench for mux_rr_arbiter: directed scenarios followed by randomized
// traffic, all compared against a cycle-level behavioural model of the
// arbiter rules.

module tb_mux_rr_arbiter;

  localparam int HOLD = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] req_s;
  logic [15:0] data_s;
  logic        rel_s;
  logic [3:0]  sel_s;
  logic [15:0] gnt_s;
  logic        gnt_valid_s;
  logic        data_out_s;
  logic        dout_valid_s;

  int checks;
  int errors;

  // Model state: mode 0 = idle, 1 = granting, 2 = guard.
  int m_mode;
  int m_ptr;
  int m_sel;
  int m_age;   // 1-based number of the current grant cycle
  bit m_dout;
  bit m_dv;

  mux_rr_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req_s),
    .data_in    (data_s),
    .release_i  (rel_s),
    .sel        (sel_s),
    .gnt        (gnt_s),
    .gnt_valid  (gnt_valid_s),
    .data_out   (data_out_s),
    .dout_valid (dout_valid_s)
  );

  // Free-running clock with a 10-time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First requesting index after p, going round the ring and ending at p.
  function automatic int rr_next(input logic [15:0] r, input int p);
    for (int k = 1; k <= 16; k++) begin
      if (r[(p + k) % 16]) return (p + k) % 16;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_ptr = 15; m_sel = 0; m_age = 0; m_dout = 1'b0; m_dv = 1'b0;
  endtask

  task automatic model_edge(input logic [15:0] r, input logic [15:0] d, input logic rel);
    int w;
    if (m_mode == 1) begin
      m_dout = d[m_sel];
      m_dv   = 1'b1;
      if (rel || !r[m_sel] || m_age == HOLD) m_mode = 2;
      else m_age++;
    end else begin
      m_dv = 1'b0;
      w = rr_next(r, m_ptr);
      if (w >= 0) begin
        m_mode = 1; m_sel = w; m_ptr = w; m_age = 1;
      end else begin
        m_mode = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] exp_gnt;
    exp_gnt = (m_mode == 1) ? (16'd1 << m_sel) : 16'd0;
    chk({tag, ".sel"},        {12'd0, sel_s},        16'(m_sel));
    chk({tag, ".gnt"},        gnt_s,                 exp_gnt);
    chk({tag, ".gnt_valid"},  {15'd0, gnt_valid_s},  16'(m_mode == 1));
    chk({tag, ".data_out"},   {15'd0, data_out_s},   {15'd0, m_dout});
    chk({tag, ".dout_valid"}, {15'd0, dout_valid_s}, {15'd0, m_dv});
    chk({tag, ".onehot"},     16'($countones(gnt_s) <= 1), 16'd1);
    chk({tag, ".gnt_sel"},    {15'd0, gnt_s[sel_s]}, {15'd0, gnt_valid_s});
  endtask

  // One clock: inputs seen at the edge feed the model, and outputs are checked 1 unit later.
  task automatic tick(input string tag);
    logic [15:0] r;
    logic [15:0] d;
    logic        rel;
    r = req_s; d = data_s; rel = rel_s;
    @(posedge clk);
    model_edge(r, d, rel);
    #1;
    check_all(tag);
  endtask

  // Mid-cycle asynchronous reset pulse; outputs must clear with no clock edge.
  task automatic mid_reset(input string tag);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, ".sel0"},  {12'd0, sel_s},        16'd0);
    chk({tag, ".gnt0"},  gnt_s,                 16'd0);
    chk({tag, ".gv0"},   {15'd0, gnt_valid_s},  16'd0);
    chk({tag, ".do0"},   {15'd0, data_out_s},   16'd0);
    chk({tag, ".dv0"},   {15'd0, dout_valid_s}, 16'd0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    req_s = 16'd0; data_s = 16'd0; rel_s = 1'b0; rst_n = 1'b1;

    // Reset asserted before any clock edge; outputs must clear immediately.
    #2 rst_n = 1'b0;
    #1;
    chk("por.gnt", gnt_s, 16'd0);
    chk("por.gv",  {15'd0, gnt_valid_s}, 16'd0);
    chk("por.sel", {12'd0, sel_s}, 16'd0);
    chk("por.dv",  {15'd0, dout_valid_s}, 16'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick("idle");
      chk("idle.gnt", gnt_s, 16'd0);
    end

    // Sole requester 5: four grant cycles, one GUARD cycle, then granted again.
    req_s = 16'h0020; data_s = 16'h0020;
    for (int c = 0; c < 4; c++) begin
      tick("sole");
      chk("sole.gnt", gnt_s, 16'h0020);
      chk("sole.sel", {12'd0, sel_s}, 16'd5);
      if (c > 0) chk("sole.dout", {15'd0, data_out_s, dout_valid_s}, 16'd3);
    end
    tick("sole_guard");
    chk("sole.guard_gnt", gnt_s, 16'h0000);
    chk("sole.guard_dout", {15'd0, data_out_s, dout_valid_s}, 16'd3);
    tick("sole_regrant");
    chk("sole.regrant", gnt_s, 16'h0020);

    // Two requesters alternate starting from source 0, four cycles each, with a GUARD cycle between grants.
    mid_reset("rst_a");
    req_s = 16'h8001; data_s = 16'h8000;
    for (int g = 0; g < 4; g++) begin
      for (int c = 0; c < 4; c++) begin
        tick("fair");
        chk("fair.gnt", gnt_s, (g % 2 == 0) ? 16'h0001 : 16'h8000);
      end
      tick("fair_guard");
      chk("fair.guard", gnt_s, 16'h0000);
    end

    // Release in the 2nd grant cycle gives a 2-cycle grant; pending source 3 wins next.
    mid_reset("rst_b");
    req_s = 16'h000A; data_s = 16'h0000;
    tick("rel_c1");
    chk("rel.first", gnt_s, 16'h0002);
    tick("rel_c2");
    rel_s = 1'b1;
    tick("rel_guard");
    chk("rel.guard", gnt_s, 16'h0000);
    rel_s = 1'b0;
    tick("rel_next");
    chk("rel.next_sel", {12'd0, sel_s}, 16'd3);

    // Request drop during the grant of source 7 leads to GUARD, then IDLE.
    mid_reset("rst_c");
    req_s = 16'h0080;
    tick("drop_c1");
    chk("drop.sel", {12'd0, sel_s}, 16'd7);
    req_s = 16'h0000;
    tick("drop_guard");
    chk("drop.guard", gnt_s, 16'h0000);
    tick("drop_idle");
    tick("drop_idle2");
    chk("drop.idle", {15'd0, gnt_valid_s}, 16'd0);

    // Reset during the grant of source 9; source 0 gets first priority afterwards.
    mid_reset("rst_d");
    req_s = 16'h0200;
    tick("r9_c1");
    chk("r9.sel", {12'd0, sel_s}, 16'd9);
    tick("r9_c2");
    mid_reset("rst_mid");
    req_s = 16'h0201;
    tick("r9_after");
    chk("r9.after_sel", {12'd0, sel_s}, 16'd0);

    // Randomized traffic with occasional mid-run resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req_s = 16'($urandom & $urandom & $urandom);
      data_s = 16'($urandom);
      rel_s  = ($urandom_range(0, 7) == 0);
      if (i % 150 == 149) mid_reset("rnd_rst");
      tick("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
